uart_tx_scheduler: RTL and testbench

//  Shares the single 16-bit UART transmit word path between NREQ game-data

---
 rtl/uart_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 16-bit UART word path between NREQ requesters.
// Each word carries its requester index in [15:12]; a watchdog drops words whose tx_done never arrives.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20000,
  parameter int CW      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*12-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_done,
  output logic              busy,
  output logic [3:0]        grant_id,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        rr_ptr_reg, rr_ptr_next;
  logic [15:0]       tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [NREQ-1:0]   req_ready_reg, req_ready_next;
  logic              busy_reg, busy_next;
  logic [3:0]        grant_id_reg, grant_id_next;
  logic [CW-1:0]     timer_reg, timer_next;
  logic              timeout_err_reg, timeout_err_next;

  logic [11:0]       payload [16];
  logic [15:0]       valid_ext;
  logic [15:0]       grant_onehot;
  logic [4:0]        idx;
  logic [3:0]        grant;
  logic              found;
  logic [3:0]        next_ptr;

  // Pad payloads and valids to 16 entries so a 4-bit grant can index them directly.
  for (genvar gi = 0; gi < 16; gi++) begin : g_payload
    if (gi < NREQ) begin : g_used
      assign payload[gi] = req_data[12*gi +: 12];
    end else begin : g_unused
      assign payload[gi] = 12'd0;
    end
  end

  assign valid_ext    = 16'(req_valid);
  assign grant_onehot = 16'd1 << grant;
  assign next_ptr     = (grant_id_reg == 4'(NREQ - 1)) ? 4'd0 : grant_id_reg + 4'd1;

  // Search upward from rr_ptr, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = 4'd0;
    idx   = 5'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_reg} + 5'(k);
      if (idx >= 5'(NREQ)) idx = idx - 5'(NREQ);
      if (!found && valid_ext[idx[3:0]]) begin
        found = 1'b1;
        grant = idx[3:0];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = tx_valid_reg;
    req_ready_next   = '0;
    grant_id_next    = grant_id_reg;
    timer_next       = timer_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          tx_data_next   = {grant, payload[grant]};
          grant_id_next  = grant;
          tx_valid_next  = 1'b1;
          req_ready_next = grant_onehot[NREQ-1:0];
          state_next     = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          timer_next    = '0;
          state_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_next = timer_reg + 1'b1;
        // tx_done takes priority over a simultaneous expiry.
        if (tx_done) begin
          state_next  = IDLE;
          rr_ptr_next = next_ptr;
        end else if (timer_reg == CW'(TIMEOUT - 1)) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
          rr_ptr_next      = next_ptr;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= 4'd0;
      tx_data_reg     <= 16'd0;
      tx_valid_reg    <= 1'b0;
      req_ready_reg   <= '0;
      busy_reg        <= 1'b0;
      grant_id_reg    <= 4'd0;
      timer_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      req_ready_reg   <= req_ready_next;
      busy_reg        <= busy_next;
      grant_id_reg    <= grant_id_next;
      timer_reg       <= timer_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign req_ready   = req_ready_reg;
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign busy        = busy_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected words are queued as stimulus is driven
// and compared whenever the DUT hands a word to the converter.
module tb_uart_tx_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = 5;

  localparam logic [11:0] P0 = 12'h111;
  localparam logic [11:0] P1 = 12'h222;
  localparam logic [11:0] P2 = 12'hABC;
  localparam logic [11:0] P3 = 12'h333;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*12-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_done;
  logic              busy;
  logic [3:0]        grant_id;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;
  int rdy_pulses = 0;
  int handoffs   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_word;
  logic [15:0] exp_onehot;

  uart_tx_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge: inputs change just after the rising edge, so values are stable here.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (req_ready !== '0) begin
        rdy_pulses++;
        exp_onehot = 16'd1 << tx_data[15:12];
        check("rdy_onehot", 32'(req_ready), 32'(exp_onehot[NREQ-1:0]));
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        handoffs++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          mon_word = exp_q.pop_front();
          check("sb_word", 32'(tx_data), 32'(mon_word));
          $display("word handed off: tx_data=%h expected=%h", tx_data, mon_word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (tx_valid !== 1'b1) check("wait_valid_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic serve_word(input int done_delay);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (done_delay - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int got_k;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = {P3, P2, P1, P0};
    tx_ready  = 1'b0;
    tx_done   = 1'b0;

    // 1: reset held with all requesters valid
    req_valid = 4'hF;
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    exp_q.push_back({4'd0, P0});
    rst = 1'b1;
    wait_valid();
    req_valid = '0;
    check("first_grant", 32'(grant_id), 32'd0);
    serve_word(3);

    // 2: single requester, zero-wait handoff, tx_done 5 cycles after handoff
    tx_ready  = 1'b1;
    req_valid = 4'b0100;
    exp_q.push_back(16'h2ABC);
    tick();
    check("single_req_ready", 32'(req_ready), 32'b0100);
    check("single_tx_valid", 32'(tx_valid), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'h2ABC);
    req_valid = '0;
    tick();
    tx_ready = 1'b0;
    check("single_ready_pulse", 32'(req_ready), 32'd0);
    check("single_valid_drop", 32'(tx_valid), 32'd0);
    check("single_busy_wait", 32'(busy), 32'd1);
    repeat (4) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("single_busy_done", 32'(busy), 32'd0);
    check("single_data_hold", 32'(tx_data), 32'h2ABC);

    // 3: round robin with all requesters held valid
    do_reset();
    begin
      int p0;
      p0 = rdy_pulses;
      exp_q.push_back({4'd0, P0});
      exp_q.push_back({4'd1, P1});
      exp_q.push_back({4'd2, P2});
      exp_q.push_back({4'd3, P3});
      exp_q.push_back({4'd0, P0});
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
        wait_valid();
        if (i == 4) req_valid = '0;
        serve_word(3);
      end
      check("rr_pulses", 32'(rdy_pulses - p0), 32'd5);
    end

    // 4: backpressure for 10 cycles
    req_valid = 4'b0001;
    exp_q.push_back({4'd0, P0});
    wait_valid();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'({4'd0, P0}));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("bp_handoff", 32'(tx_valid), 32'd0);
    repeat (2) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // 5: watchdog expiry, then next grant goes to g+1
    req_valid = 4'b0010;
    exp_q.push_back({4'd1, P1});
    wait_valid();
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    got_k = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (timeout_err === 1'b1) begin
        got_k = k;
        break;
      end
    end
    check("to_cycles", 32'(got_k), 32'(TIMEOUT));
    tick();
    check("to_one_pulse", 32'(timeout_err), 32'd0);
    req_valid = 4'b1101;
    exp_q.push_back({4'd2, P2});
    wait_valid();
    req_valid = '0;
    check("to_next_grant", 32'(grant_id), 32'd2);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("to_done_wins", 32'(timeout_err), 32'd0);
    check("to_done_idle", 32'(busy), 32'd0);
    tick();
    check("to_done_quiet", 32'(timeout_err), 32'd0);

    // 6: reset during WAIT_DONE, stray tx_done afterwards
    req_valid = 4'b1000;
    exp_q.push_back({4'd3, P3});
    wait_valid();
    req_valid = '0;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    rst     = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_err", 32'(timeout_err), 32'd0);
    req_valid = 4'hF;
    exp_q.push_back({4'd0, P0});
    wait_valid();
    req_valid = '0;
    check("post_rst_grant", 32'(grant_id), 32'd0);
    serve_word(2);

    tick();
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    check("handoff_count", 32'(handoffs), 32'd12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
